// File: rtl/ib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ib_pkg                                                               |
// | Shared types and constants for the per-warp instruction buffer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ib_pkg;

  localparam int NUM_WARPS = 8;
  localparam int IB_DEPTH  = 4;

  localparam logic [3:0] c_ALU_ADD = 4'h0;
  localparam logic [3:0] c_ALU_SUB = 4'h1;
  localparam logic [3:0] c_ALU_AND = 4'h2;
  localparam logic [3:0] c_ALU_OR  = 4'h3;
  localparam logic [3:0] c_ALU_XOR = 4'h4;
  localparam logic [3:0] c_ALU_SLL = 4'h5;
  localparam logic [3:0] c_ALU_SRL = 4'h6;
  localparam logic [3:0] c_ALU_SRA = 4'h7;
  localparam logic [3:0] c_ALU_SLT = 4'h8;
  localparam logic [3:0] c_ALU_MUL = 4'h9;

  // Instr occupies the top 32 bits of the packed entry.
  typedef struct packed {
    logic [31:0] Instr;
    logic [4:0]  Src1;
    logic [4:0]  Src2;
    logic [4:0]  Dst;
    logic [15:0] Imme;
    logic [3:0]  ALUop;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        Exit;
    logic        Shared_Globalbar;
    logic        Src1_Valid;
    logic        Src2_Valid;
    logic        Imme_Valid;
    logic        BEQ;
    logic        BLT;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage
`default_nettype wire

// File: rtl/ib_warp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ib_warp_fifo                                                         |
// | Single-warp FIFO: two ordered write lanes, one pop, flush.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ib_warp_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 77,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr0_en,
  input  logic [ENTRY_W-1:0] wr0_data,
  input  logic               wr1_en,
  input  logic [ENTRY_W-1:0] wr1_data,
  input  logic               pop_req,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head_data,
  output logic [CNT_W-1:0]   count,
  output logic               pop,
  output logic               overflow
);
  import ib_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [CNT_W:0]     w_space;
  logic               w_acc0;
  logic               w_acc1;
  logic [PTR_W-1:0]   w_wr1_slot;

  assign pop = pop_req && (r_count != '0) && !flush;

  // Space counts the slot freed by this cycle's pop.
  assign w_space = (CNT_W+1)'(DEPTH) - {1'b0, r_count} + {{CNT_W{1'b0}}, pop};

  // Lane 1 only fits if there is room left after lane 0.
  assign w_acc0     = wr0_en && !flush && (w_space != '0);
  assign w_acc1     = wr1_en && !flush && (w_space > {{CNT_W{1'b0}}, w_acc0});
  assign w_wr1_slot = r_wr_ptr + {{(PTR_W-1){1'b0}}, w_acc0};
  assign overflow   = !flush && ((wr0_en && !w_acc0) || (wr1_en && !w_acc1));

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, pop};
      r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, w_acc0} + {{(PTR_W-1){1'b0}}, w_acc1};
      r_count  <= r_count + {{(CNT_W-1){1'b0}}, w_acc0} + {{(CNT_W-1){1'b0}}, w_acc1}
                  - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wr_ptr]   <= wr0_data;
    if (w_acc1) r_mem[w_wr1_slot] <= wr1_data;
  end

endmodule
`default_nettype wire

// File: rtl/ibuffer_warp_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ibuffer_warp_queue                                                   |
// | Per-warp decoded-instruction buffer between decode and issue.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ibuffer_warp_queue #(
  parameter int NUM_WARPS = ib_pkg::NUM_WARPS,
  parameter int DEPTH     = ib_pkg::IB_DEPTH,
  parameter int ENTRY_W   = ib_pkg::ENTRY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENTRY_W-1:0]   Entry_ID0_IB,
  input  logic [ENTRY_W-1:0]   Entry_ID1_IB,
  input  logic [NUM_WARPS-1:0] Valid_ID0_IB,
  input  logic [NUM_WARPS-1:0] Valid_ID1_IB,
  input  logic [NUM_WARPS-1:0] Flush_Warp,
  input  logic [NUM_WARPS-1:0] Issue_Grant,
  output logic [ENTRY_W-1:0]   Head_Entry_IB_Issue,
  output logic                 Head_Valid_IB_Issue,
  output logic [NUM_WARPS-1:0] Ready_IB_Sched,
  output logic [NUM_WARPS-1:0] Full_IB_IF,
  output logic                 Overflow_Err
);
  import ib_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0]   w_fifo_head [NUM_WARPS];
  logic [CNT_W-1:0]     w_count     [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_pop;
  logic [NUM_WARPS-1:0] w_ovf;
  logic [ENTRY_W-1:0]   w_head;
  logic                 r_overflow;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    ib_warp_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W),
      .CNT_W   (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr0_en    (Valid_ID0_IB[g]),
      .wr0_data  (Entry_ID0_IB),
      .wr1_en    (Valid_ID1_IB[g]),
      .wr1_data  (Entry_ID1_IB),
      .pop_req   (Issue_Grant[g]),
      .flush     (Flush_Warp[g]),
      .head_data (w_fifo_head[g]),
      .count     (w_count[g]),
      .pop       (w_pop[g]),
      .overflow  (w_ovf[g])
    );

    assign Ready_IB_Sched[g] = (w_count[g] != '0);
    assign Full_IB_IF[g]     = (w_count[g] > CNT_W'(DEPTH - 2));
  end

  // A flushed but non-empty granted warp still shows its head, unpopped.
  always_comb begin
    w_head = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (Issue_Grant[w] && (w_count[w] != '0)) w_head = w_head | w_fifo_head[w];
    end
  end

  assign Head_Entry_IB_Issue = w_head;
  assign Head_Valid_IB_Issue = |w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= r_overflow | (|w_ovf);
  end

  assign Overflow_Err = r_overflow;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(Issue_Grant));

endmodule
`default_nettype wire

// File: tb/tb_ibuffer_warp_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ibuffer_warp_queue                                                |
// | Directed plus random stimulus against a queue-based warp model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ibuffer_warp_queue;
  import ib_pkg::*;

  localparam int NW = 8;
  localparam int D  = 4;
  localparam int EW = 77;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [EW-1:0] e0, e1;
  logic [NW-1:0] v0, v1, fl, gr;
  logic [EW-1:0] head_entry;
  logic          head_valid;
  logic [NW-1:0] ready, full;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] mq [NW][$];
  logic          m_ovf;
  entry_t        he;

  always #5 clk = ~clk;

  ibuffer_warp_queue #(.NUM_WARPS(NW), .DEPTH(D), .ENTRY_W(EW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .Entry_ID0_IB        (e0),
    .Entry_ID1_IB        (e1),
    .Valid_ID0_IB        (v0),
    .Valid_ID1_IB        (v1),
    .Flush_Warp          (fl),
    .Issue_Grant         (gr),
    .Head_Entry_IB_Issue (head_entry),
    .Head_Valid_IB_Issue (head_valid),
    .Ready_IB_Sched      (ready),
    .Full_IB_IF          (full),
    .Overflow_Err        (ovf)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] rand_entry();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[EW-1:0];
  endfunction

  function automatic logic [EW-1:0] mk(input logic [31:0] instr);
    entry_t e;
    e = entry_t'(rand_entry());
    e.Instr = instr;
    return e;
  endfunction

  task automatic drive(input logic [NW-1:0] a0, input logic [NW-1:0] a1,
                       input logic [NW-1:0] af, input logic [NW-1:0] ag,
                       input logic [EW-1:0] d0, input logic [EW-1:0] d1);
    v0 = a0; v1 = a1; fl = af; gr = ag; e0 = d0; e1 = d1;
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic look();
    logic          x_hv;
    logic [EW-1:0] x_he;
    logic [NW-1:0] x_rdy, x_full;
    @(negedge clk);
    x_hv = 1'b0; x_he = '0;
    for (int w = 0; w < NW; w++) begin
      if (gr[w] && mq[w].size() > 0) begin
        x_he = mq[w][0];
        x_hv = !fl[w];
      end
      x_rdy[w]  = (mq[w].size() != 0);
      x_full[w] = (mq[w].size() > D - 2);
    end
    check("head_valid", 128'(head_valid), 128'(x_hv));
    check("head_entry", 128'(head_entry), 128'(x_he));
    check("ready",      128'(ready),      128'(x_rdy));
    check("full",       128'(full),       128'(x_full));
    check("overflow",   128'(ovf),        128'(m_ovf));
  endtask

  // Apply this cycle's inputs to the model, then advance past the clock edge.
  task automatic tick();
    int cap;
    for (int w = 0; w < NW; w++) begin
      if (fl[w]) begin
        mq[w].delete();
      end else begin
        if (gr[w] && mq[w].size() > 0) void'(mq[w].pop_front());
        cap = D - mq[w].size();
        if (v0[w]) begin
          if (cap > 0) begin mq[w].push_back(e0); cap--; end
          else m_ovf = 1'b1;
        end
        if (v1[w]) begin
          if (cap > 0) begin mq[w].push_back(e1); cap--; end
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [EW-1:0] ea, eb;
    logic [NW-1:0] oh0, oh1;
    int            w0, w1;
    m_ovf = 1'b0;
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    look();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write to warp 2, pop next cycle.
    drive(8'h04, '0, '0, '0, mk(32'h2001_0005), '0); look(); tick();
    drive('0, '0, '0, 8'h04, '0, '0); look();
    check("t1_ready", 128'(ready), 128'(8'h04));
    he = entry_t'(head_entry);
    check("t1_instr", 128'(he.Instr), 128'(32'h2001_0005));
    tick();
    drive('0, '0, '0, '0, '0, '0); look();
    check("t1_ready_after", 128'(ready), 128'(8'h00));
    tick();

    // Dual write to warp 3, popped in port order.
    ea = mk(32'hAAAA_0001); eb = mk(32'hBBBB_0002);
    drive(8'h08, 8'h08, '0, '0, ea, eb); look(); tick();
    drive('0, '0, '0, 8'h08, '0, '0); look();
    check("t2_full3", 128'(full[3]), 128'(1'b0));
    he = entry_t'(head_entry);
    check("t2_first", 128'(he.Instr), 128'(32'hAAAA_0001));
    tick();
    drive('0, '0, '0, 8'h08, '0, '0); look();
    he = entry_t'(head_entry);
    check("t2_second", 128'(he.Instr), 128'(32'hBBBB_0002));
    tick();

    // Fill warp 0, then write with pop, then overflow.
    drive(8'h01, 8'h01, '0, '0, rand_entry(), rand_entry()); look(); tick();
    drive(8'h01, 8'h01, '0, '0, rand_entry(), rand_entry()); look(); tick();
    drive(8'h01, '0, '0, 8'h01, rand_entry(), '0); look(); tick();
    drive('0, '0, '0, '0, '0, '0); look();
    check("t3_no_ovf", 128'(ovf), 128'(1'b0));
    check("t3_full0", 128'(full[0]), 128'(1'b1));
    tick();
    drive(8'h01, '0, '0, '0, rand_entry(), '0); look(); tick();
    drive('0, '0, '0, '0, '0, '0); look();
    check("t3_ovf", 128'(ovf), 128'(1'b1));
    tick();
    look();
    check("t3_ovf_sticky", 128'(ovf), 128'(1'b1));
    tick();

    // Flush warp 5 with concurrent write and grant.
    drive(8'h20, 8'h20, '0, '0, rand_entry(), rand_entry()); look(); tick();
    drive(8'h20, '0, '0, '0, rand_entry(), '0); look(); tick();
    drive(8'h20, '0, 8'h20, 8'h20, rand_entry(), '0); look();
    check("t4_hv", 128'(head_valid), 128'(1'b0));
    tick();
    drive('0, '0, '0, '0, '0, '0); look();
    check("t4_ready5", 128'(ready[5]), 128'(1'b0));
    tick();

    // Wrap-around on warp 7.
    drive(8'h80, '0, '0, '0, mk(32'h7000_0000), '0); look(); tick();
    for (int i = 1; i < 10; i++) begin
      drive(8'h80, '0, '0, 8'h80, mk(32'h7000_0000 + 32'(i)), '0); look();
      he = entry_t'(head_entry);
      check("t5_wrap", 128'(he.Instr), 128'(32'h7000_0000 + 32'(i - 1)));
      tick();
    end
    drive('0, '0, '0, 8'h80, '0, '0); look();
    he = entry_t'(head_entry);
    check("t5_last", 128'(he.Instr), 128'(32'h7000_0009));
    tick();

    // Entries in every warp, then asynchronous reset mid-cycle.
    for (int w = 0; w < NW; w++) begin
      oh0 = 8'(1) << w;
      drive(oh0, oh0, '0, '0, rand_entry(), rand_entry()); look(); tick();
    end
    drive(8'h01, '0, '0, 8'h02, rand_entry(), '0); look();
    rst_n = 1'b0;
    #1;
    check("t6_ready",  128'(ready),      128'(8'h00));
    check("t6_full",   128'(full),       128'(8'h00));
    check("t6_hv",     128'(head_valid), 128'(1'b0));
    check("t6_he",     128'(head_entry), 128'(0));
    check("t6_ovf",    128'(ovf),        128'(1'b0));
    for (int w = 0; w < NW; w++) mq[w].delete();
    m_ovf = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    look();
    check("t6_ready_rel", 128'(ready), 128'(8'h00));
    tick();

    // Random traffic; fetch honours Full so no overflow is expected.
    for (int n = 0; n < 400; n++) begin
      w0 = $urandom_range(0, NW - 1);
      w1 = $urandom_range(0, NW - 1);
      oh0 = '0; oh1 = '0;
      if ($urandom_range(0, 1) == 1 && mq[w0].size() <= D - 2) oh0 = 8'(1) << w0;
      if ($urandom_range(0, 1) == 1 && mq[w1].size() <= D - 2) oh1 = 8'(1) << w1;
      drive(oh0, oh1,
            ($urandom_range(0, 15) == 0) ? 8'(1) << $urandom_range(0, NW - 1) : 8'h00,
            ($urandom_range(0, 3) != 0) ? 8'(1) << $urandom_range(0, NW - 1) : 8'h00,
            rand_entry(), rand_entry());
      look();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibuffer_warp_queue.md
Name: ibuffer_warp_queue

Overview:
Per-warp instruction buffer that receives the dual-issue decoded instruction stream (ports 0 and 1, each tagged with a one-hot warp ID). It holds decoded entries in one small FIFO per warp. Each cycle it presents the head of the warp granted by the scoreboard/issue scheduler and pops that entry. It returns per-warp occupancy and stall status to fetch, and drops queued entries when a warp is redirected by branch/SIMT resolution.

Parameters:
NUM_WARPS, 8, number of warps; width of all one-hot warp vectors
DEPTH, 4, entries per warp FIFO; power of 2, >= 2
ENTRY_W, 77, packed decoded-entry width (layout in ib_pkg)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Entry_ID0_IB  in  ENTRY_W  packed decoded entry, port 0 (older in program order)
Entry_ID1_IB  in  ENTRY_W  packed decoded entry, port 1
Valid_ID0_IB  in  NUM_WARPS  one-hot (or zero) write enable for port 0
Valid_ID1_IB  in  NUM_WARPS  one-hot (or zero) write enable for port 1
Flush_Warp  in  NUM_WARPS  drop all entries of flagged warps
Issue_Grant  in  NUM_WARPS  one-hot (or zero) pop request from scheduler
Head_Entry_IB_Issue  out  ENTRY_W  head entry of granted warp; zero if none
Head_Valid_IB_Issue  out  1  granted warp non-empty, so a pop occurs
Ready_IB_Sched  out  NUM_WARPS  per-warp non-empty
Full_IB_IF  out  NUM_WARPS  per-warp stall to fetch
Overflow_Err  out  1  sticky; a write was discarded

Behaviour:
- Reset (async assert, sync release): all pointers, counts and Overflow_Err cleared. Ready_IB_Sched=0, Full_IB_IF=0, Head_Valid=0, Head_Entry=0.
- Each warp has its own FIFO: rd_ptr/wr_ptr of log2(DEPTH) bits wrapping modulo DEPTH, and count of log2(DEPTH)+1 bits.
- Write: a port writes warp w when Valid_IDx[w]=1.
  - Both ports on the same warp in one cycle: ID0 goes to slot wr_ptr, ID1 to wr_ptr+1; wr_ptr advances by 2.
- Pop: when Issue_Grant[w]=1 and count_w>0, combinationally drive Head_Entry = mem_w[rd_ptr_w] and Head_Valid=1, then rd_ptr_w++ at the clock edge.
  - Grant to an empty warp, or Issue_Grant=0: Head_Valid=0, Head_Entry=0, no state change.
  - Non-one-hot grant: undefined; flagged by assertion only.
- Capacity:
  - space = DEPTH - count + pop_this_cycle.
  - Writes are accepted in port order while space remains. A write that does not fit is discarded, and Overflow_Err is set and held until reset.
  - Simultaneous write and pop on a full warp is legal; count is unchanged.
- Flush_Warp[w]=1: count_w, rd_ptr_w and wr_ptr_w go to 0 next cycle. Flush beats same-cycle writes and pop for that warp, which are ignored for warp w. Head output is still shown but Head_Valid=0 for a flushed warp.
- Ready_IB_Sched[w] = (count_w != 0), taken from registered state.
- Full_IB_IF[w] = (count_w > DEPTH-2), taken from registered state, i.e. fewer than 2 free slots. Fetch may send at most one instruction per port per warp per cycle, so fetch never overflows while it honours Full.
- Latency: a write in cycle N is visible on Ready and poppable in cycle N+1. No write-to-head bypass.
- count update: count_w_next = count_w + writes_accepted - pop.

Decomposition:
- ib_pkg:
  - NUM_WARPS.
  - Entry typedef with fields Instr[32], Src1[5], Src2[5], Dst[5], Imme[16], ALUop[4], and flags RegWrite, MemWrite, MemRead, Exit, Shared_Globalbar, Src1_Valid, Src2_Valid, Imme_Valid, BEQ, BLT (77 bits total).
  - ALUop constants.
- Sub-module ib_warp_fifo: one DEPTH-entry FIFO with 2 write lanes, 1 pop and flush, instantiated NUM_WARPS times. The top level does the one-hot demux, the head mux and the Overflow_Err OR.

Test Plan:
- Reset, then write Valid_ID0=8'h04 with Instr=32'h2001_0005 → next cycle Ready=8'h04; Grant=8'h04 gives Head_Valid=1 and Head.Instr=32'h2001_0005; following cycle Ready=8'h00.
- Same-cycle ID0 (Instr A) and ID1 (Instr B) to warp 3 → Full_IB_IF[3]=0 (count 2, DEPTH 4); two grants pop A then B in order.
- Fill warp 0 to 4 entries; then write 1 entry plus Grant warp 0 in the same cycle → accepted, count stays 4, Overflow_Err=0. A further write with no grant → discarded, Overflow_Err=1 and stays 1.
- Warp 5 holds 3 entries; Flush_Warp=8'h20 in the same cycle as an ID0 write and a grant to warp 5 → Head_Valid=0, next cycle Ready[5]=0 and count 0.
- Wrap-around: 10 push/pop pairs on warp 7 with incrementing Instr values → popped sequence matches pushed sequence across pointer wrap.
- Assert rst_n low with entries in all warps → all outputs 0 immediately, without waiting for a clock; after release, Ready=0.
